// File: rtl/ifetch_queue_pkg.sv
// Shared RV configuration for the instruction fetch queue: instruction width,
// NOP encoding and the fetch-alignment helper.
`ifndef XLEN
`define XLEN 32
`endif

package ifetch_queue_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned FETCH_STRIDE = 4;

  // A fetch PC is misaligned when it is not on a 4-byte boundary.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Synchronous FIFO with registered head, synchronous flush and a reset value
// for every storage slot so the head reads a defined word straight out of reset.
module sync_fifo #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 2,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  // Pop only when something is held; push only when a slot is (or becomes) free.
  assign pop_en  = pop_i & (count_q != '0);
  assign push_en = push_i & ((count_q != CNT_W'(DEPTH)) | pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_DATA;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en && !flush_i) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential PC generation against a combinational
// instruction memory, redirect handling and a small decoupling queue to decode.
`ifndef XLEN
`define XLEN 32
`endif

module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN         = `XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     DEPTH        = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_misaligned
);

  localparam int unsigned ENTRY_W = XLEN + INSTR_W + 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = {XLEN'(0), NOP_INSTR, 1'b0};

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              push_c;
  logic              pop_c;
  logic              misaligned_c;
  logic              head_valid;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] push_entry;
  logic [CNT_W-1:0]  fifo_count;

  assign misaligned_c = pc_misaligned(fetch_pc_q[1:0]);
  assign pop_c        = head_valid & out_ready;
  assign push_entry   = {fetch_pc_q, imem_instr, misaligned_c};

  // Redirect wins over everything; a misaligned fetch is queued once then halts.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push_c     = 1'b0;
    if (redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc;
    end else begin
      case (state_q)
        RUN: begin
          if ((fifo_count < CNT_W'(DEPTH)) || pop_c) begin
            push_c = 1'b1;
            if (misaligned_c) begin
              state_d = HALT;
            end else begin
              fetch_pc_d = fetch_pc_q + XLEN'(FETCH_STRIDE);
            end
          end
        end
        HALT: begin
          push_c = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (DEPTH),
    .RESET_DATA (RESET_ENTRY)
  ) u_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (redirect_valid),
    .push_i  (push_c),
    .data_i  (push_entry),
    .pop_i   (pop_c),
    .valid_o (head_valid),
    .data_o  (head_entry),
    .count_o (fifo_count)
  );

  assign imem_addr      = fetch_pc_q;
  assign out_valid      = head_valid;
  assign out_pc         = head_entry[ENTRY_W-1 -: XLEN];
  assign out_instr      = head_entry[INSTR_W:1];
  assign out_misaligned = head_entry[0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: sequential fetch, backpressure, redirect,
// misaligned halt, PC wrap and mid-stream reset.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, out_misaligned;
  logic [31:0] out_pc, out_instr;

  logic [31:0] w_imem_addr, w_imem_instr;
  logic        w_out_valid, w_out_misaligned;
  logic [31:0] w_out_pc, w_out_instr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory word for address a: 0x00500093, 0x00A00113, 0x00F00193, ...
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {2'b00, a[31:2]};
    return 32'h0050_0093 + idx * 32'h0050_0080;
  endfunction

  assign imem_instr   = imem_word(imem_addr);
  assign w_imem_instr = imem_word(w_imem_addr);

  ifetch_queue #(.XLEN(32), .RESET_VECTOR(32'h0), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned)
  );

  ifetch_queue #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (w_imem_addr),
    .imem_instr     (w_imem_instr),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (w_out_valid),
    .out_ready      (1'b1),
    .out_pc         (w_out_pc),
    .out_instr      (w_out_instr),
    .out_misaligned (w_out_misaligned)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(out_pc), 64'h0);
    check("rst_instr", 64'(out_instr), 64'h13);
    check("rst_mis", 64'(out_misaligned), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'h0);

    // Sequential fetch with decode always ready
    reset = 1'b0; out_ready = 1'b1;
    check("boot_addr", 64'(imem_addr), 64'h0);
    step();
    check("seq0_valid", 64'(out_valid), 64'd1);
    check("seq0_pc", 64'(out_pc), 64'h0);
    check("seq0_instr", 64'(out_instr), 64'h0050_0093);
    check("wrap0_pc", 64'(w_out_pc), 64'hFFFF_FFFC);
    step();
    check("seq1_pc", 64'(out_pc), 64'h4);
    check("seq1_instr", 64'(out_instr), 64'h00A0_0113);
    check("wrap1_valid", 64'(w_out_valid), 64'd1);
    check("wrap1_pc", 64'(w_out_pc), 64'h0);
    check("wrap1_instr", 64'(w_out_instr), 64'h0050_0093);
    step();
    check("seq2_pc", 64'(out_pc), 64'h8);
    check("seq2_instr", 64'(out_instr), 64'h00F0_0193);

    // Backpressure from a fresh reset
    reset = 1'b1; out_ready = 1'b0;
    step();
    reset = 1'b0;
    check("bp_empty", 64'(out_valid), 64'd0);
    step(); step(); step();
    check("bp_hold3_pc", 64'(out_pc), 64'h0);
    check("bp_hold3_addr", 64'(imem_addr), 64'h8);
    step(); step();
    check("bp_hold5_valid", 64'(out_valid), 64'd1);
    check("bp_hold5_pc", 64'(out_pc), 64'h0);
    check("bp_hold5_instr", 64'(out_instr), 64'h0050_0093);
    check("bp_hold5_addr", 64'(imem_addr), 64'h8);
    out_ready = 1'b1;
    step();
    check("bp_rel0_pc", 64'(out_pc), 64'h4);
    step();
    check("bp_rel1_pc", 64'(out_pc), 64'h8);
    check("bp_rel1_instr", 64'(out_instr), 64'h00F0_0193);
    step();
    check("bp_rel2_valid", 64'(out_valid), 64'd1);
    check("bp_rel2_pc", 64'(out_pc), 64'hC);

    // Redirect coincident with a pop
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 64'(out_valid), 64'd0);
    check("rd_addr", 64'(imem_addr), 64'h100);
    step();
    check("rd_valid", 64'(out_valid), 64'd1);
    check("rd_pc", 64'(out_pc), 64'h100);
    check("rd_instr", 64'(out_instr), 64'h1450_2093);
    check("rd_mis", 64'(out_misaligned), 64'd0);
    step();
    check("rd_next_pc", 64'(out_pc), 64'h104);

    // Misaligned target: one entry, then halt until a new redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    check("mis_flush_valid", 64'(out_valid), 64'd0);
    step();
    check("mis_valid", 64'(out_valid), 64'd1);
    check("mis_pc", 64'(out_pc), 64'h102);
    check("mis_flag", 64'(out_misaligned), 64'd1);
    step();
    check("halt_valid0", 64'(out_valid), 64'd0);
    check("halt_addr", 64'(imem_addr), 64'h102);
    step(); step();
    check("halt_valid2", 64'(out_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("restart_gap", 64'(out_valid), 64'd0);
    step();
    check("restart_valid", 64'(out_valid), 64'd1);
    check("restart_pc", 64'(out_pc), 64'h200);
    check("restart_instr", 64'(out_instr), 64'h2850_4093);
    check("restart_mis", 64'(out_misaligned), 64'd0);

    // Mid-stream reset with two entries queued
    out_ready = 1'b0;
    step();
    check("mr_pre_pc", 64'(out_pc), 64'h200);
    check("mr_pre_addr", 64'(imem_addr), 64'h208);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_addr", 64'(imem_addr), 64'h0);
    step();
    check("mr_first_pc", 64'(out_pc), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
